vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised video timing generator; successor to the fixed 640x480 driver and its clock halver. Runs directly on the 50 MHz board clock, derives a pixel clock-enable internally, and produces registered sync, data-enable, position, line/frame strobes and an optional frame counter. Sits between the board clock and the Game of Life pixel/RAM pipeline; a configurable output delay aligns sync with pixel data.

## Interface
- CLK_DIV, 2: clk_in cycles per pixel (>=1; 1 = every cycle)
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal pixels
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical lines
- H_POL, 0 / V_POL, 0: sync active level (0 = active-low)
- CW, 10: width of sx/sy; must hold H_TOTAL-1 and V_TOTAL-1
- DELAY, 0: extra pixel-stage delay on all outputs, 0..7
- FRAME_W, 16: frame counter width
- clk_in  in  1  board clock, 50 MHz
- rst  in  1  reset, synchronous, active-high
- pix_ce  out  1  one-clk_in pulse each pixel period; outputs newly valid this cycle
- sx  out  CW  horizontal position
- sy  out  CW  vertical position
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- de  out  1  high in active area
- line_start  out  1  high while sx == 0
- frame_start  out  1  high while sx == 0 and sy == 0
- frame_cnt  out  FRAME_W  completed frames (VGA_TIMING_FRAME_CNT_EN only)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Divider div_cnt counts 0..CLK_DIV-1; internal ce = (div_cnt == CLK_DIV-1).
- On ce: decoded bundle of current (hc, vc) enters output stage 0; hc increments; at hc == H_TOTAL-1 hc -> 0 and vc increments, wrapping at V_TOTAL-1 -> 0.
- Decode: de = hc < H_ACTIVE && vc < V_ACTIVE; hsync active for H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC (656..751); vsync active for lines 490..491.
- DELAY further stages, each shifting only on ce; last stage drives outputs. Outputs hold between ce pulses.
- pix_ce = ce registered once (not delayed by DELAY); marks the cycle outputs change.
- All arithmetic unsigned CW bits; no counter exceeds TOTAL-1.

## Timing
- Reset values: div_cnt, hc, vc = 0; every pipeline stage and output: sx = sy = 0, de = 0, line_start = frame_start = 0, pix_ce = 0, hsync = ~H_POL, vsync = ~V_POL, frame_cnt = 0.
- rst overrides ce and all updates in the same cycle; mid-frame reset returns to (0,0) with divider phase 0.
- First non-reset cycle = cycle 0; ce in cycle CLK_DIV-1; pix_ce and outputs for (0,0) (DELAY = 0) in cycle CLK_DIV.
- Latency counter -> output: 1 clk_in + DELAY pixel periods.
- Frame period: H_TOTAL*V_TOTAL*CLK_DIV clk_in cycles (840000 default).
- CLK_DIV = 1: ce constant high, pix_ce high every cycle after the first.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments on ce when (hc, vc) wraps from (H_TOTAL-1, V_TOTAL-1) to (0,0); the value travels in the output bundle, updating in the same output cycle where frame_start rises; wraps 2^FRAME_W-1 -> 0. First frame after reset reads 0.
- Undefined: no counter logic; frame_cnt driven constant 0.

## Test plan
- Defaults, release rst: pix_ce first high in cycle 2 with sx=0, sy=0, de=1, frame_start=1, hsync=vsync=1; pix_ce period exactly 2 cycles.
- Defaults, one line: de high for sx 0..639, hsync low exactly for sx 656..751, line_start at sx=0, sx wraps 799 -> 0 with sy+1.
- Defaults, full frame: vsync low for sy 490..491; frame_start repeats every 840000 cycles; frame_cnt 0 -> 1 on second frame_start (macro on), stays 0 (macro off).
- DELAY=3, H_POL=V_POL=1: outputs lag DELAY=0 instance by exactly 3 pix_ce pulses; hsync high during 656..751.
- CLK_DIV=1, H_ACTIVE=4, H_FP=H_SYNC=H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1: sx sequence 0..6, sy 0..4, frame every 35 cycles.
- Assert rst at sx=300, sy=200 for one cycle: next cycle outputs at reset values; (0,0) reappears CLK_DIV cycles after release.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with internal pixel clock-enable
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CW       = 10,
    parameter int DELAY    = 0,
    parameter int FRAME_W  = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    output logic               pix_ce,
    output logic [CW-1:0]      sx,
    output logic [CW-1:0]      sy,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic [CW-1:0]      x;
        logic [CW-1:0]      y;
        logic               hs;
        logic               vs;
        logic               de;
        logic               ls;
        logic               fs;
        logic [FRAME_W-1:0] fc;
    } bundle_t;

    localparam bundle_t RESET_BUNDLE = '{
        x: '0, y: '0, hs: ~H_POL, vs: ~V_POL,
        de: 1'b0, ls: 1'b0, fs: 1'b0, fc: '0
    };

    logic [DW-1:0]      div_cnt;
    logic               ce;
    logic [CW-1:0]      hc;
    logic [CW-1:0]      vc;
    logic               hc_last;
    logic               vc_last;
    logic [FRAME_W-1:0] fcnt;
    bundle_t            cur;
    bundle_t            pipe [DELAY+1];

    assign ce      = (div_cnt == DIV_LAST);
    assign hc_last = (hc == H_LAST);
    assign vc_last = (vc == V_LAST);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (ce) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (ce) begin
            if (hc_last) begin
                hc <= '0;
                vc <= vc_last ? '0 : vc + 1'b1;
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    // Counts completed frames; the new value rides with the (0,0) bundle.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            fcnt <= '0;
        end else if (ce && hc_last && vc_last) begin
            fcnt <= fcnt + 1'b1;
        end
    end
`else
    assign fcnt = '0;
`endif

    always_comb begin
        cur    = RESET_BUNDLE;
        cur.x  = hc;
        cur.y  = vc;
        cur.de = (hc < H_ACT) && (vc < V_ACT);
        cur.hs = ((hc >= HS_BEG) && (hc < HS_END)) ? H_POL : ~H_POL;
        cur.vs = ((vc >= VS_BEG) && (vc < VS_END)) ? V_POL : ~V_POL;
        cur.ls = (hc == '0);
        cur.fs = (hc == '0) && (vc == '0);
        cur.fc = fcnt;
    end

    // Stage 0 is the registered decode; DELAY further stages align sync with downstream pixel data.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            pix_ce <= 1'b0;
            for (int i = 0; i <= DELAY; i++) begin
                pipe[i] <= RESET_BUNDLE;
            end
        end else begin
            pix_ce <= ce;
            if (ce) begin
                pipe[0] <= cur;
                for (int i = 1; i <= DELAY; i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign sx          = pipe[DELAY].x;
    assign sy          = pipe[DELAY].y;
    assign hsync       = pipe[DELAY].hs;
    assign vsync       = pipe[DELAY].vs;
    assign de          = pipe[DELAY].de;
    assign line_start  = pipe[DELAY].ls;
    assign frame_start = pipe[DELAY].fs;
    assign frame_cnt   = pipe[DELAY].fc;

endmodule
